// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine
//
// Decrypt stage for a 64-byte message stream that was encrypted with a 7-bit
// LFSR keystream. The first TRAIN_LEN bytes are known to be spaces, so the
// engine runs nine candidate LFSRs (one per tap pattern) against that
// preamble and keeps the ones that predict it correctly. The lowest surviving
// candidate is then used to decrypt the rest of the stream. Each decrypted
// byte is parity checked. Leading spaces are dropped, and the result is padded
// with PAD_CHAR so that exactly MSG_LEN bytes come out.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse; honoured only when idle or done
//   in_data    encrypted byte {parity, cipher[6:0]}
//   in_valid   in_data is valid
//   in_ready   engine takes in_data this cycle
//   out_data   {parity error, plain[6:0]}
//   out_addr   result index 0..MSG_LEN-1
//   out_valid  out_data/out_addr valid; held until out_ready
//   out_ready  downstream accepts the current result
//   pat_sel    index of the selected tap pattern
//   pat_err    sticky: no tap pattern matched the preamble
//   done       run complete; stays high until the next start
module lfsr_decrypt_engine #(
    parameter int         MSG_LEN   = 64,
    parameter int         TRAIN_LEN = 9,
    parameter logic [7:0] PAD_CHAR  = 8'h20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [7:0]                 out_data,
    output logic [$clog2(MSG_LEN)-1:0] out_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 pat_sel,
    output logic                       pat_err,
    output logic                       done
);

    localparam int ADDR_W = $clog2(MSG_LEN);
    localparam int CNT_W  = $clog2(MSG_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAIN,
        ST_SELECT,
        ST_STRIP,
        ST_PASS,
        ST_PAD,
        ST_DONE
    } state_t;

    function automatic logic [6:0] tap_of(input logic [3:0] idx);
        case (idx)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            4'd8:    tap_of = 7'h7B;
            default: tap_of = 7'h60;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
        lfsr_step = {s[5:0], ^(s & tap)};
    endfunction

    state_t              state_q, state_d;
    logic [8:0]          mask_q, mask_d;
    logic [6:0]          cand_q [9];
    logic [6:0]          cand_d [9];
    logic [6:0]          lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [3:0]          pat_sel_q, pat_sel_d;
    logic                pat_err_q, pat_err_d;
    logic                done_q, done_d;

    logic [6:0]          cand_step [9];
    logic [3:0]          sel_idx;
    logic                in_fire;
    logic                out_fire;
    logic                slot_free;
    logic [6:0]          train_state;
    logic [6:0]          plain;
    logic                perr;
    logic [CNT_W-1:0]    next_idx;

    // The output slot is free when it is empty or being drained this cycle;
    // this lets a new result follow the previous one without a bubble.
    assign out_fire    = out_valid_q & out_ready;
    assign slot_free   = ~out_valid_q | out_ready;
    assign in_fire     = in_valid & in_ready;
    assign train_state = in_data[6:0] ^ PAD_CHAR[6:0];
    assign plain       = in_data[6:0] ^ lfsr_q;
    assign perr        = ^in_data;
    assign next_idx    = out_cnt_q + CNT_W'(out_fire);

    // Every candidate advances with its own tap pattern.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            cand_step[i] = lfsr_step(cand_q[i], tap_of(4'(i)));
        end
    end

    // Lowest surviving candidate; falls back to 0 when none survived.
    always_comb begin
        sel_idx = '0;
        for (int i = 8; i >= 0; i--) begin
            if (mask_q[i]) begin
                sel_idx = 4'(i);
            end
        end
    end

    always_comb begin
        case (state_q)
            ST_TRAIN:          in_ready = 1'b1;
            ST_STRIP, ST_PASS: in_ready = slot_free;
            default:           in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cand_d      = cand_q;
        lfsr_d      = lfsr_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q + CNT_W'(out_fire);
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        pat_sel_d   = pat_sel_q;
        pat_err_d   = pat_err_q;
        done_d      = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_TRAIN;
                    mask_d    = 9'h1FF;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    pat_err_d = 1'b0;
                    done_d    = 1'b0;
                end
            end

            ST_TRAIN: begin
                if (in_valid) begin
                    in_cnt_d = in_cnt_q + CNT_ONE;
                    for (int i = 0; i < 9; i++) begin
                        if (in_cnt_q == '0) begin
                            cand_d[i] = train_state;
                        end else begin
                            cand_d[i] = cand_step[i];
                            if (cand_step[i] != train_state) begin
                                mask_d[i] = 1'b0;
                            end
                        end
                    end
                    if (in_cnt_q == CNT_W'(TRAIN_LEN - 1)) begin
                        state_d = ST_SELECT;
                    end
                end
            end

            // cand holds the state of the last preamble byte, so one more
            // step gives the key for the first byte after the preamble.
            ST_SELECT: begin
                pat_sel_d = sel_idx;
                pat_err_d = (mask_q == 9'h000);
                lfsr_d    = lfsr_step(cand_q[sel_idx], tap_of(sel_idx));
                state_d   = ST_STRIP;
            end

            ST_STRIP, ST_PASS: begin
                if (in_fire) begin
                    in_cnt_d = in_cnt_q + CNT_ONE;
                    lfsr_d   = lfsr_step(lfsr_q, tap_of(pat_sel_q));
                    if ((state_q == ST_PASS) || (plain != PAD_CHAR[6:0]) || perr) begin
                        out_valid_d = 1'b1;
                        out_data_d  = {perr, plain};
                        out_addr_d  = ADDR_W'(next_idx);
                        state_d     = ST_PASS;
                    end
                    if (in_cnt_q == CNT_W'(MSG_LEN - 1)) begin
                        state_d = ST_PAD;
                    end
                end
            end

            // Results already placed in the slot = out_cnt_q + out_valid_q.
            ST_PAD: begin
                if (slot_free && ((out_cnt_q + CNT_W'(out_valid_q)) < CNT_W'(MSG_LEN))) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {1'b0, PAD_CHAR[6:0]};
                    out_addr_d  = ADDR_W'(next_idx);
                end
                if (out_cnt_d == CNT_W'(MSG_LEN)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= 9'h1FF;
            for (int i = 0; i < 9; i++) begin
                cand_q[i] <= '0;
            end
            lfsr_q      <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            pat_sel_q   <= '0;
            pat_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cand_q      <= cand_d;
            lfsr_q      <= lfsr_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            pat_sel_q   <= pat_sel_d;
            pat_err_q   <= pat_err_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign pat_sel   = pat_sel_q;
    assign pat_err   = pat_err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// tb_lfsr_decrypt_engine
//
// Encrypts known messages with a chosen tap pattern and seed, streams them
// through the engine and compares the result stream against the expected
// plaintext with leading spaces removed and a space tail.
module tb_lfsr_decrypt_engine;

    localparam int MSG_LEN   = 64;
    localparam int TRAIN_LEN = 9;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [5:0] out_addr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pat_sel;
    logic       pat_err;
    logic       done;

    logic [6:0] plain_buf [MSG_LEN];
    logic [7:0] enc_buf   [MSG_LEN];
    logic [7:0] exp_buf   [MSG_LEN];
    logic [7:0] first_out;
    int         tests_run;
    int         tests_failed;
    int         n_out;

    string watson = "Mr. Watson, come here, I want to see you.";
    string fox    = "The quick brown fox jumps over the lazy dog!";

    lfsr_decrypt_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pat_sel   (pat_sel),
        .pat_err   (pat_err),
        .done      (done)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] tap_of(input int idx);
        case (idx)
            0:       tap_of = 7'h60;
            1:       tap_of = 7'h48;
            2:       tap_of = 7'h78;
            3:       tap_of = 7'h72;
            4:       tap_of = 7'h6A;
            5:       tap_of = 7'h69;
            6:       tap_of = 7'h5C;
            7:       tap_of = 7'h7E;
            default: tap_of = 7'h7B;
        endcase
    endfunction

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] tap);
        step = {s[5:0], ^(s & tap)};
    endfunction

    // Random nonzero seed for which no lower-numbered tap pattern reproduces
    // the same preamble keystream, so the intended pattern is the one chosen.
    function automatic logic [6:0] pick_init(input int pat);
        logic [6:0] seed;
        logic [6:0] s_ref;
        logic [6:0] s_alt;
        bit         clash;
        bit         same;
        for (int tries = 0; tries < 500; tries++) begin
            seed  = 7'($urandom_range(1, 127));
            clash = 1'b0;
            for (int j = 0; j < pat; j++) begin
                s_ref = seed;
                s_alt = seed;
                same  = 1'b1;
                for (int k = 1; k < TRAIN_LEN; k++) begin
                    s_ref = step(s_ref, tap_of(pat));
                    s_alt = step(s_alt, tap_of(j));
                    if (s_ref != s_alt) same = 1'b0;
                end
                if (same) clash = 1'b1;
            end
            if (!clash) return seed;
        end
        return 7'h01;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Message = pre spaces, then text, then spaces up to MSG_LEN.
    task automatic build_plain(input string text, input int pre);
        byte c;
        for (int k = 0; k < MSG_LEN; k++) begin
            if (k < pre || (k - pre) >= text.len()) begin
                plain_buf[k] = 7'h20;
            end else begin
                c = text[k - pre];
                plain_buf[k] = c[6:0];
            end
        end
    endtask

    // Expected result: message after its leading spaces, then space fill.
    task automatic build_expected();
        int f;
        f = MSG_LEN;
        for (int k = MSG_LEN - 1; k >= TRAIN_LEN; k--) begin
            if (plain_buf[k] != 7'h20) f = k;
        end
        for (int j = 0; j < MSG_LEN; j++) begin
            exp_buf[j] = (j < MSG_LEN - f) ? {1'b0, plain_buf[f + j]} : 8'h20;
        end
    endtask

    task automatic encrypt(input int pat, input logic [6:0] seed);
        logic [6:0] s;
        logic [6:0] c;
        s = seed;
        for (int k = 0; k < MSG_LEN; k++) begin
            c = plain_buf[k] ^ s;
            enc_buf[k] = {^c, c};
            s = step(s, tap_of(pat));
        end
    endtask

    // Runs one message through the engine. gap_mode adds random in_valid
    // gaps, ready_mode throttles out_ready to roughly one cycle in three,
    // abort_at >= 0 pulls reset once that many inputs have been accepted.
    task automatic applyStimulus(input bit gap_mode, input bit ready_mode, input bit check_data,
                                 input int abort_at, output int count);
        int  in_idx;
        bit  finished;
        in_idx   = 0;
        count    = 0;
        finished = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            if (abort_at >= 0 && in_idx >= abort_at) begin
                rst_n     = 1'b0;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                #1;
                checkOutput("abort_out_valid", out_valid, 0);
                checkOutput("abort_in_ready", in_ready, 0);
                checkOutput("abort_out_data", out_data, 0);
                checkOutput("abort_out_addr", out_addr, 0);
                checkOutput("abort_pat_sel", pat_sel, 0);
                checkOutput("abort_done", done, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            in_valid  = (in_idx < MSG_LEN) && (!gap_mode || $urandom_range(0, 3) != 0);
            in_data   = (in_idx < MSG_LEN) ? enc_buf[in_idx] : 8'h00;
            out_ready = !ready_mode || ($urandom_range(0, 2) == 0);
            #1;
            if (in_valid && in_ready) in_idx++;
            if (out_valid && out_ready) begin
                if (count == 0) first_out = out_data;
                checkOutput("addr", {26'b0, out_addr}, count);
                if (check_data && count < MSG_LEN) checkOutput("data", out_data, exp_buf[count]);
                count++;
            end
            if (done) finished = 1'b1;
            @(negedge clk);
        end
        checkOutput("reached_done", finished, 1);
        if (finished) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            #1;
            checkOutput("in_ready_after_done", in_ready, 0);
            checkOutput("out_valid_after_done", out_valid, 0);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        logic [6:0] seed;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        in_data      = 8'h00;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        first_out    = 8'h00;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_addr", out_addr, 0);
        checkOutput("rst_pat_sel", pat_sel, 0);
        checkOutput("rst_pat_err", pat_err, 0);
        checkOutput("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reference message: tap 0x60, seed 0x01, 12 leading spaces.
        build_plain(watson, 12);
        build_expected();
        encrypt(0, 7'h01);
        applyStimulus(1'b0, 1'b0, 1'b1, -1, n_out);
        checkOutput("watson_count", n_out, 64);
        checkOutput("watson_out0", first_out, 8'h4D);
        checkOutput("watson_pat_sel", pat_sel, 0);
        checkOutput("watson_pat_err", pat_err, 0);
        checkOutput("watson_done", done, 1);

        // Every tap pattern with a random seed and varying preamble length.
        for (int pat = 0; pat < 9; pat++) begin
            build_plain(fox, TRAIN_LEN + pat);
            build_expected();
            encrypt(pat, pick_init(pat));
            applyStimulus(1'b0, 1'b0, 1'b1, -1, n_out);
            checkOutput("sweep_count", n_out, 64);
            checkOutput("sweep_pat_sel", pat_sel, pat);
            checkOutput("sweep_pat_err", pat_err, 0);
        end

        // Single corrupted cipher bit: only that result flags a parity error.
        build_plain(watson, 12);
        build_expected();
        encrypt(3, pick_init(3));
        enc_buf[30] = enc_buf[30] ^ 8'h08;
        exp_buf[18] = {1'b1, plain_buf[30] ^ 7'h08};
        applyStimulus(1'b0, 1'b0, 1'b1, -1, n_out);
        checkOutput("flip_count", n_out, 64);
        checkOutput("flip_pat_sel", pat_sel, 3);

        // Back-pressure and input gaps must not change the result stream.
        build_plain(watson, 12);
        build_expected();
        encrypt(5, pick_init(5));
        applyStimulus(1'b1, 1'b1, 1'b1, -1, n_out);
        checkOutput("stall_count", n_out, 64);
        checkOutput("stall_pat_sel", pat_sel, 5);

        // Corrupted preamble byte: no pattern can fit.
        build_plain(watson, 12);
        build_expected();
        encrypt(2, pick_init(2));
        enc_buf[4] = enc_buf[4] ^ 8'h01;
        applyStimulus(1'b0, 1'b0, 1'b0, -1, n_out);
        checkOutput("badtrain_count", n_out, 64);
        checkOutput("badtrain_pat_err", pat_err, 1);
        checkOutput("badtrain_pat_sel", pat_sel, 0);
        checkOutput("badtrain_done", done, 1);

        // All-space message: entire result is space fill.
        build_plain("", MSG_LEN);
        build_expected();
        seed = pick_init(4);
        encrypt(4, seed);
        applyStimulus(1'b0, 1'b1, 1'b1, -1, n_out);
        checkOutput("spaces_count", n_out, 64);
        checkOutput("spaces_pat_sel", pat_sel, 4);

        // Reset in the middle of a run, then a clean restart.
        applyStimulus(1'b0, 1'b0, 1'b1, 40, n_out);
        build_plain(watson, 12);
        build_expected();
        encrypt(0, 7'h01);
        applyStimulus(1'b0, 1'b0, 1'b1, -1, n_out);
        checkOutput("restart_count", n_out, 64);
        checkOutput("restart_out0", first_out, 8'h4D);
        checkOutput("restart_pat_err", pat_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
